// File: rtl/mem_access_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_master: turns one MEM-stage load/store into a timed ram2_* bus   |
// | cycle with lane selects, store replication and load extension.             |
// | Optional macro UART_MMIO_FAST_EN: serial MMIO addresses skip HOLD.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_access_master #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic        req_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        stall_o,
  output logic [31:0] ram2_addr_o,
  output logic [31:0] ram2_data_o,
  input  logic [31:0] ram2_data_i,
  output logic        ram2_we_o,
  output logic [3:0]  ram2_sel_o,
  output logic        ram2_ce_o
);

`ifdef UART_MMIO_FAST_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  localparam logic [3:0]  HOLD_INIT = 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] UART_DATA = 32'hBFD0_03F8;
  localparam logic [31:0] UART_STAT = 32'hBFD0_03FC;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HOLD, S_DONE, S_ERR} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [2:0]  op_q;
  logic [1:0]  lo_q;
  logic        fast_q;
  logic        busy;

  logic        is_store;
  logic        misaligned;
  logic        fast_hit;

  function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lo +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (op)
      3'd0:    load_ext = {{24{b[7]}}, b};
      3'd1:    load_ext = {24'd0, b};
      3'd2:    load_ext = {{16{h[15]}}, h};
      3'd3:    load_ext = {16'd0, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input logic [2:0] op, input logic [1:0] lo);
    case (op)
      3'd0, 3'd1, 3'd5: lane_sel = ~(4'b0001 << lo);
      3'd2, 3'd3, 3'd6: lane_sel = lo[1] ? 4'b0011 : 4'b1100;
      default:          lane_sel = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_rep(input logic [2:0] op, input logic [31:0] d);
    case (op)
      3'd5:    store_rep = {4{d[7:0]}};
      3'd6:    store_rep = {2{d[15:0]}};
      default: store_rep = d;
    endcase
  endfunction

  assign is_store   = op_i[2] & (op_i[1] | op_i[0]);
  assign misaligned = ((op_i == 3'd2 || op_i == 3'd3 || op_i == 3'd6) && addr_i[0]) ||
                      ((op_i == 3'd4 || op_i == 3'd7) && addr_i[1:0] != 2'b00);
  assign fast_hit   = FAST_EN && (addr_i == UART_DATA || addr_i == UART_STAT);

  // The pipeline must freeze in the very cycle a request appears, before the FSM reacts.
  assign stall_o = busy | ((state == S_IDLE) & req_i);

  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      op_q        <= 3'd0;
      lo_q        <= 2'd0;
      fast_q      <= 1'b0;
      busy        <= 1'b0;
      rdata_o     <= 32'd0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      ram2_addr_o <= 32'd0;
      ram2_data_o <= 32'd0;
      ram2_we_o   <= 1'b1;
      ram2_sel_o  <= 4'b1111;
      ram2_ce_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_i) begin
            if (misaligned) begin
              state   <= S_ERR;
              done_o  <= 1'b1;
              err_o   <= 1'b1;
              rdata_o <= 32'd0;
            end else begin
              state       <= S_SETUP;
              busy        <= 1'b1;
              op_q        <= op_i;
              lo_q        <= addr_i[1:0];
              fast_q      <= fast_hit;
              cnt         <= HOLD_INIT;
              ram2_ce_o   <= 1'b1;
              ram2_addr_o <= {addr_i[31:2], 2'b00};
              ram2_sel_o  <= lane_sel(op_i, addr_i[1:0]);
              ram2_data_o <= store_rep(op_i, wdata_i);
              // Fast MMIO stores have no HOLD, so they strobe during SETUP.
              ram2_we_o   <= ~(fast_hit & is_store);
            end
          end
        end
        S_SETUP: begin
          if (fast_q) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            done_o     <= 1'b1;
            rdata_o    <= load_ext(op_q, lo_q, ram2_data_i);
            ram2_ce_o  <= 1'b0;
            ram2_we_o  <= 1'b1;
            ram2_sel_o <= 4'b1111;
          end else begin
            state     <= S_HOLD;
            ram2_we_o <= ~(op_q[2] & (op_q[1] | op_q[0]));
          end
        end
        S_HOLD: begin
          if (cnt == 4'd0) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            done_o     <= 1'b1;
            rdata_o    <= load_ext(op_q, lo_q, ram2_data_i);
            ram2_ce_o  <= 1'b0;
            ram2_we_o  <= 1'b1;
            ram2_sel_o <= 4'b1111;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_access_master: randomized self-checking bench with a behavioural     |
// | per-cycle model of the bus access sequence.                                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_access_master;

  localparam int W = 3;

  logic        clk_50M = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic [31:0] rdata_o;
  logic        done_o;
  logic        err_o;
  logic        stall_o;
  logic [31:0] ram2_addr_o;
  logic [31:0] ram2_data_o;
  logic [31:0] ram2_data_i = 32'd0;
  logic        ram2_we_o;
  logic [3:0]  ram2_sel_o;
  logic        ram2_ce_o;

  int total = 0;
  int bad = 0;

  mem_access_master #(.WAIT_CYCLES(W)) dut (
    .clk_50M(clk_50M), .rst(rst), .req_i(req_i), .op_i(op_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o),
    .stall_o(stall_o), .ram2_addr_o(ram2_addr_o), .ram2_data_o(ram2_data_o),
    .ram2_data_i(ram2_data_i), .ram2_we_o(ram2_we_o), .ram2_sel_o(ram2_sel_o),
    .ram2_ce_o(ram2_ce_o)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One complete access, compared cycle by cycle with what the bus rules demand.
  task automatic access(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] word, input bit gap);
    bit          st, mis, fast;
    int          lat, b, h;
    logic [3:0]  xsel;
    logic [31:0] xdata, xrd, lane;
    st   = (o >= 3'd5);
    mis  = ((o == 3'd2 || o == 3'd3 || o == 3'd6) && (a % 2 != 0)) ||
           ((o == 3'd4 || o == 3'd7) && (a % 4 != 0));
`ifdef UART_MMIO_FAST_EN
    fast = (a == 32'hBFD003F8) || (a == 32'hBFD003FC);
`else
    fast = 1'b0;
`endif
    b = int'(a % 4);
    h = int'((a / 2) % 2);
    xsel = 4'hF;
    if (o == 3'd0 || o == 3'd1 || o == 3'd5) xsel[b] = 1'b0;
    else if (o == 3'd2 || o == 3'd3 || o == 3'd6) begin
      xsel[2*h] = 1'b0;
      xsel[2*h+1] = 1'b0;
    end else xsel = 4'h0;
    if (o == 3'd5)      xdata = (d & 32'hFF) * 32'h01010101;
    else if (o == 3'd6) xdata = (d & 32'hFFFF) * 32'h00010001;
    else                xdata = d;
    case (o)
      3'd0, 3'd1: begin
        lane = (word >> (8 * b)) & 32'hFF;
        xrd = (o == 3'd0 && lane >= 32'd128) ? lane - 32'd256 : lane;
      end
      3'd2, 3'd3: begin
        lane = (word >> (16 * h)) & 32'hFFFF;
        xrd = (o == 3'd2 && lane >= 32'h8000) ? lane - 32'h10000 : lane;
      end
      default: xrd = word;
    endcase
    lat = fast ? 2 : W + 2;

    @(negedge clk_50M);
    req_i = 1'b1; op_i = o; addr_i = a; wdata_i = d; ram2_data_i = word;
    #1;
    check("stall_req", 32'(stall_o), 32'd1);
    if (mis) begin
      @(negedge clk_50M);
      check("err_done", 32'(done_o), 32'd1);
      check("err_flag", 32'(err_o), 32'd1);
      check("err_stall", 32'(stall_o), 32'd0);
      check("err_ce", 32'(ram2_ce_o), 32'd0);
      check("err_rdata", rdata_o, 32'd0);
    end else begin
      for (int k = 1; k < lat; k++) begin
        @(negedge clk_50M);
        check("bus_ce", 32'(ram2_ce_o), 32'd1);
        check("bus_stall", 32'(stall_o), 32'd1);
        check("bus_done", 32'(done_o), 32'd0);
        check("bus_addr", ram2_addr_o, a & 32'hFFFFFFFC);
        check("bus_sel", 32'(ram2_sel_o), 32'(xsel));
        if (st) check("bus_data", ram2_data_o, xdata);
        if (k == 1 && !fast) check("setup_we", 32'(ram2_we_o), 32'd1);
        else                 check("hold_we", 32'(ram2_we_o), st ? 32'd0 : 32'd1);
      end
      @(negedge clk_50M);
      check("done", 32'(done_o), 32'd1);
      check("done_err", 32'(err_o), 32'd0);
      check("done_stall", 32'(stall_o), 32'd0);
      check("done_ce", 32'(ram2_ce_o), 32'd0);
      check("done_we", 32'(ram2_we_o), 32'd1);
      check("done_sel", 32'(ram2_sel_o), 32'hF);
      if (!st) check("rdata", rdata_o, xrd);
    end
    req_i = 1'b0;
    if (gap) begin
      @(negedge clk_50M);
      check("idle_done", 32'(done_o), 32'd0);
      check("idle_stall", 32'(stall_o), 32'd0);
    end
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a;
    #2 rst = 1'b0;
    #1;
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_addr", ram2_addr_o, 32'd0);
    check("rst_data", ram2_data_o, 32'd0);
    check("rst_we", 32'(ram2_we_o), 32'd1);
    check("rst_sel", 32'(ram2_sel_o), 32'hF);
    check("rst_ce", 32'(ram2_ce_o), 32'd0);
    repeat (3) @(negedge clk_50M);
    rst = 1'b1;

    access(3'd4, 32'h80400004, 32'd0, 32'hDEADBEEF, 1'b1);
    access(3'd5, 32'h80400003, 32'h000000A5, 32'd0, 1'b1);
    access(3'd0, 32'h80000002, 32'd0, 32'h0080FF00, 1'b0);
    access(3'd1, 32'h80000002, 32'd0, 32'h0080FF00, 1'b0);
    access(3'd4, 32'h80400002, 32'd0, 32'h12345678, 1'b1);
    access(3'd5, 32'hBFD003F8, 32'h00000041, 32'd0, 1'b1);
    access(3'd2, 32'hBFD003FC, 32'd0, 32'h8001F00F, 1'b0);

    // Reset while a store is in HOLD: bus must drop at once with no completion.
    @(negedge clk_50M);
    req_i = 1'b1; op_i = 3'd7; addr_i = 32'h80400010; wdata_i = 32'hCAFEF00D;
    repeat (2) @(negedge clk_50M);
    check("pre_rst_we", 32'(ram2_we_o), 32'd0);
    #2 rst = 1'b0; req_i = 1'b0;
    #1;
    check("mid_rst_we", 32'(ram2_we_o), 32'd1);
    check("mid_rst_ce", 32'(ram2_ce_o), 32'd0);
    check("mid_rst_done", 32'(done_o), 32'd0);
    check("mid_rst_stall", 32'(stall_o), 32'd0);
    @(negedge clk_50M);
    check("post_rst_done", 32'(done_o), 32'd0);
    rst = 1'b1;
    access(3'd4, 32'h80400010, 32'd0, 32'h0BADF00D, 1'b1);

    for (int i = 0; i < 80; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (o == 3'd2 || o == 3'd3 || o == 3'd6) a[0] = 1'b0;
        if (o == 3'd4 || o == 3'd7) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 1) ? 32'hBFD003F8 : 32'hBFD003FC;
      access(o, a, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
